// File: rtl/moore_sequence_detector.sv
// Moore FSM that flags every (overlapping) occurrence of 1101 on a serial bit stream.
// Define SEQ_COUNT_EN to add the wrapping match counter output match_cnt.
module moore_sequence_detector #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
`ifdef SEQ_COUNT_EN
   output logic [CNT_W-1:0] match_cnt,
`endif
   output logic             dout
);

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4
   } state_t;

   state_t state_q;
   state_t state_d;
   logic   dout_q;

   // S4 falls back to S2 so the trailing "11" can seed the next match.
   function automatic state_t next_state(input state_t cur, input logic bit_in);
      state_t nxt;
      case (cur)
         S0:      nxt = bit_in ? S1 : S0;
         S1:      nxt = bit_in ? S2 : S0;
         S2:      nxt = bit_in ? S2 : S3;
         S3:      nxt = bit_in ? S4 : S0;
         S4:      nxt = bit_in ? S2 : S0;
         default: nxt = S0;
      endcase
      return nxt;
   endfunction

   always_comb begin
      state_d = next_state(state_q, din);
   end

`ifdef SEQ_COUNT_EN
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      if (state_d == S4) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S0;
         dout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         dout_q  <= (state_d == S4);
         cnt_q   <= cnt_d;
      end
   end

   assign match_cnt = cnt_q;
`else
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S0;
         dout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dout_q  <= (state_d == S4);
      end
   end
`endif

   // A zero-width counter is meaningless; the block name flags it in elaboration output.
   if (CNT_W == 0) begin : g_invalid_cnt_w
   end

   assign dout = dout_q;

endmodule

// File: tb/tb_moore_sequence_detector.sv
// Directed-vector bench for moore_sequence_detector; wrap checks run when SEQ_COUNT_EN is defined.
module tb_moore_sequence_detector;

`ifdef SEQ_COUNT_EN
   localparam int unsigned CW = 2;
`else
   localparam int unsigned CW = 8;
`endif

   logic clk;
   logic reset;
   logic din;
   logic dout;
`ifdef SEQ_COUNT_EN
   logic [CW-1:0] match_cnt;
`endif

   int total = 0;
   int bad   = 0;

   moore_sequence_detector #(.CNT_W(CW)) dut (
      .clk      (clk),
      .reset    (reset),
      .din      (din),
`ifdef SEQ_COUNT_EN
      .match_cnt(match_cnt),
`endif
      .dout     (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one bit, clock it in, and return dout sampled just after the edge.
   task automatic shift(input logic b, output logic q);
      din = b;
      @(posedge clk);
      #1;
      q = dout;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      #2;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      logic q;
      din   = 1'b1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (dout !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold[%0d]: dout=%b want 0", i, dout);
         end
`ifdef SEQ_COUNT_EN
         total++;
         if (match_cnt !== '0) begin
            bad++;
            $display("FAIL reset_cnt[%0d]: match_cnt=%0d want 0", i, match_cnt);
         end
`endif
         din = ~din;
         @(negedge clk);
      end
      reset = 1'b1;
      // From S0, 1,1,0 must not yet match; a leftover state would.
      shift(1'b1, q);
      shift(1'b1, q);
      shift(1'b0, q);
      total++;
      if (q !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: dout=%b want 0", q);
      end
   endtask

   task automatic test_overlap();
      logic [8:0] pat;
      logic [8:0] exp;
      logic q;
      apply_reset();
      pat = 9'b101101101;
      exp = 9'b000001001;
      for (int i = 8; i >= 0; i--) begin
         shift(pat[i], q);
         total++;
         if (q !== exp[i]) begin
            bad++;
            $display("FAIL overlap[%0d]: dout=%b want %b", 8 - i, q, exp[i]);
         end
      end
`ifdef SEQ_COUNT_EN
      total++;
      if (match_cnt !== 2'd2) begin
         bad++;
         $display("FAIL overlap_cnt: match_cnt=%0d want 2", match_cnt);
      end
`endif
   endtask

   task automatic test_self_overlap();
      logic [5:0] pat;
      logic [5:0] exp;
      logic q;
      apply_reset();
      pat = 6'b111101;
      exp = 6'b000001;
      for (int i = 5; i >= 0; i--) begin
         shift(pat[i], q);
         total++;
         if (q !== exp[i]) begin
            bad++;
            $display("FAIL self_overlap[%0d]: dout=%b want %b", 5 - i, q, exp[i]);
         end
      end
      // Pulse lasts exactly one cycle even when din keeps feeding 1s.
      shift(1'b1, q);
      total++;
      if (q !== 1'b0) begin
         bad++;
         $display("FAIL self_overlap_width: dout=%b want 0", q);
      end
   endtask

   task automatic test_non_match();
      logic [7:0] pat;
      logic q;
      apply_reset();
      pat = 8'b10010100;
      for (int i = 7; i >= 0; i--) begin
         shift(pat[i], q);
         total++;
         if (q !== 1'b0) begin
            bad++;
            $display("FAIL non_match[%0d]: dout=%b want 0", 7 - i, q);
         end
      end
`ifdef SEQ_COUNT_EN
      total++;
      if (match_cnt !== 2'd0) begin
         bad++;
         $display("FAIL non_match_cnt: match_cnt=%0d want 0", match_cnt);
      end
`endif
   endtask

   task automatic test_async_reset();
      logic [3:0] pat;
      logic [3:0] exp;
      logic q;
      apply_reset();
      shift(1'b1, q);
      shift(1'b1, q);
      shift(1'b0, q);
      #2;
      reset = 1'b0;
      #2;
      reset = 1'b1;
      shift(1'b1, q);
      total++;
      if (q !== 1'b0) begin
         bad++;
         $display("FAIL async_lost: dout=%b want 0", q);
      end
      pat = 4'b1101;
      exp = 4'b0001;
      for (int i = 3; i >= 0; i--) begin
         shift(pat[i], q);
         total++;
         if (q !== exp[i]) begin
            bad++;
            $display("FAIL async_after[%0d]: dout=%b want %b", 3 - i, q, exp[i]);
         end
      end
      // Reset between edges must clear a high dout without waiting for a clock.
      #2;
      reset = 1'b0;
      #1;
      total++;
      if (dout !== 1'b0) begin
         bad++;
         $display("FAIL async_clear: dout=%b want 0", dout);
      end
      #1;
      reset = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic [9:0] pat;
      logic [9:0] exp;
      logic q;
      apply_reset();
      pat = 10'b1101101101;
      exp = 10'b0001001001;
      for (int i = 9; i >= 0; i--) begin
         shift(pat[i], q);
         total++;
         if (q !== exp[i]) begin
            bad++;
            $display("FAIL back_to_back[%0d]: dout=%b want %b", 9 - i, q, exp[i]);
         end
      end
   endtask

`ifdef SEQ_COUNT_EN
   task automatic test_count_wrap();
      logic [3:0] pat;
      logic [CW-1:0] exp_cnt [5];
      logic q;
      apply_reset();
      exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      pat = 4'b1101;
      for (int k = 0; k < 5; k++) begin
         for (int i = 3; i >= 0; i--) begin
            shift(pat[i], q);
         end
         total++;
         if (match_cnt !== exp_cnt[k]) begin
            bad++;
            $display("FAIL count_wrap[%0d]: match_cnt=%0d want %0d", k, match_cnt, exp_cnt[k]);
         end
         shift(1'b0, q);
      end
   endtask
`endif

   initial begin
      reset = 1'b0;
      din   = 1'b0;
      test_reset();
      test_overlap();
      test_self_overlap();
      test_non_match();
      test_async_reset();
      test_back_to_back();
`ifdef SEQ_COUNT_EN
      test_count_wrap();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
